// File: rtl/video_timing_gen.sv
//------------------------------------------------------------------------------
// video_timing_gen
//
// Raster timing generator and output stage for the video path. Free-running
// horizontal/vertical pixel counters feed the character BG layer; the layer's
// color comes back PIPELINE_DELAY cycles later and is re-timed here together
// with data-enable and both syncs, so all video outputs line up.
//
// Ports:
//   clk           pixel clock (single clock domain)
//   reset         synchronous, active-low reset (0 = reset)
//   count_h       horizontal counter, 0..H_TOTAL-1, registered
//   count_v       vertical counter, 0..V_TOTAL-1, registered
//   color_in      pixel color from BG layer, valid PIPELINE_DELAY cycles
//                 after its count
//   color_out     registered pixel color, 0 outside the active area
//   vga_hs        horizontal sync, latency-aligned, active level SYNC_POL
//   vga_vs        vertical sync, latency-aligned, active level SYNC_POL
//   vga_de        data enable, latency-aligned
//   vblank_pulse  one-cycle pulse when the counters reach (0, V_VISIBLE)
//   frame_count   frames completed (counted at each vblank), wraps at 2^32
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module video_timing_gen #(
    parameter int unsigned H_VISIBLE      = 640,
    parameter int unsigned H_FRONT        = 16,
    parameter int unsigned H_SYNC         = 96,
    parameter int unsigned H_BACK         = 48,
    parameter int unsigned V_VISIBLE      = 480,
    parameter int unsigned V_FRONT        = 10,
    parameter int unsigned V_SYNC         = 2,
    parameter int unsigned V_BACK         = 33,
    parameter bit          SYNC_POL       = 1'b0,
    parameter int unsigned PIPELINE_DELAY = 9
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] count_h,
    output logic [31:0] count_v,
    input  logic [7:0]  color_in,
    output logic [7:0]  color_out,
    output logic        vga_hs,
    output logic        vga_vs,
    output logic        vga_de,
    output logic        vblank_pulse,
    output logic [31:0] frame_count
);

    localparam logic [31:0] H_LAST     = 32'(H_VISIBLE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [31:0] V_LAST     = 32'(V_VISIBLE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [31:0] H_VIS      = 32'(H_VISIBLE);
    localparam logic [31:0] V_VIS      = 32'(V_VISIBLE);
    localparam logic [31:0] HS_START   = 32'(H_VISIBLE + H_FRONT);
    localparam logic [31:0] HS_END     = 32'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [31:0] VS_START   = 32'(V_VISIBLE + V_FRONT);
    localparam logic [31:0] VS_END     = 32'(V_VISIBLE + V_FRONT + V_SYNC);
    localparam logic [31:0] V_VIS_PREV = 32'(V_VISIBLE - 1);

    //--------------------------------------------------------------------------
    // Raster counters, vblank pulse and frame counter
    //--------------------------------------------------------------------------
    logic [31:0] count_h_q, count_h_d;
    logic [31:0] count_v_q, count_v_d;
    logic [31:0] frame_count_q, frame_count_d;
    logic        vblank_q, vblank_d;
    logic        h_wrap;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path through the block can leave it unassigned and infer a latch.
    always_comb begin
        h_wrap        = (count_h_q == H_LAST);
        count_h_d     = count_h_q + 32'd1;
        count_v_d     = count_v_q;
        frame_count_d = frame_count_q;
        vblank_d      = 1'b0;

        if (h_wrap) begin
            count_h_d = '0;
            count_v_d = (count_v_q == V_LAST) ? '0 : count_v_q + 32'd1;
        end

        // The pulse is registered, so it is raised on the edge that moves the
        // counters onto (0, V_VISIBLE); it is then high in exactly that cycle.
        if (h_wrap && (count_v_q == V_VIS_PREV)) begin
            vblank_d      = 1'b1;
            frame_count_d = frame_count_q + 32'd1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            count_h_q     <= '0;
            count_v_q     <= '0;
            frame_count_q <= '0;
            vblank_q      <= 1'b0;
        end else begin
            count_h_q     <= count_h_d;
            count_v_q     <= count_v_d;
            frame_count_q <= frame_count_d;
            vblank_q      <= vblank_d;
        end
    end

    //--------------------------------------------------------------------------
    // Raw raster flags from the current counts (sync flags are active-high
    // internally; polarity is applied only at the output register)
    //--------------------------------------------------------------------------
    logic de_raw, hs_raw, vs_raw;

    always_comb begin
        de_raw = (count_h_q < H_VIS) && (count_v_q < V_VIS);
        hs_raw = (count_h_q >= HS_START) && (count_h_q < HS_END);
        vs_raw = (count_v_q >= VS_START) && (count_v_q < VS_END);
    end

    //--------------------------------------------------------------------------
    // Delay line matching the BG layer latency
    //--------------------------------------------------------------------------
    logic de_dly, hs_dly, vs_dly;

    if (PIPELINE_DELAY == 0) begin : g_no_delay
        assign de_dly = de_raw;
        assign hs_dly = hs_raw;
        assign vs_dly = vs_raw;
    end else begin : g_delay
        logic [PIPELINE_DELAY-1:0] de_sr_q;
        logic [PIPELINE_DELAY-1:0] hs_sr_q;
        logic [PIPELINE_DELAY-1:0] vs_sr_q;

        // NOTE: the delay line is a shift register, not a RAM, and it is reset
        // on purpose: a reset mid-frame must not let stale enables or syncs
        // from the aborted frame drain out after release.
        always_ff @(posedge clk) begin
            if (!reset) begin
                de_sr_q <= '0;
                hs_sr_q <= '0;
                vs_sr_q <= '0;
            end else begin
                de_sr_q[0] <= de_raw;
                hs_sr_q[0] <= hs_raw;
                vs_sr_q[0] <= vs_raw;
                for (int i = 1; i < int'(PIPELINE_DELAY); i++) begin
                    de_sr_q[i] <= de_sr_q[i-1];
                    hs_sr_q[i] <= hs_sr_q[i-1];
                    vs_sr_q[i] <= vs_sr_q[i-1];
                end
            end
        end

        assign de_dly = de_sr_q[PIPELINE_DELAY-1];
        assign hs_dly = hs_sr_q[PIPELINE_DELAY-1];
        assign vs_dly = vs_sr_q[PIPELINE_DELAY-1];
    end

    //--------------------------------------------------------------------------
    // Output register: color is blanked wherever the aligned enable is low
    //--------------------------------------------------------------------------
    logic [7:0] color_q;
    logic       de_q, hs_q, vs_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            color_q <= 8'h00;
            de_q    <= 1'b0;
            hs_q    <= ~SYNC_POL;
            vs_q    <= ~SYNC_POL;
        end else begin
            color_q <= de_dly ? color_in : 8'h00;
            de_q    <= de_dly;
            hs_q    <= hs_dly ? SYNC_POL : ~SYNC_POL;
            vs_q    <= vs_dly ? SYNC_POL : ~SYNC_POL;
        end
    end

    assign count_h      = count_h_q;
    assign count_v      = count_v_q;
    assign frame_count  = frame_count_q;
    assign vblank_pulse = vblank_q;
    assign color_out    = color_q;
    assign vga_de       = de_q;
    assign vga_hs       = hs_q;
    assign vga_vs       = vs_q;

endmodule

// File: tb/tb_video_timing_gen.sv
//------------------------------------------------------------------------------
// tb_video_timing_gen
//
// Two reduced-size instances (different timings, sync polarities, and
// delays including zero) share clock, reset and a random color stream. A
// reference model derives every expected output from the number of clock
// edges since reset release using plain modular arithmetic over the
// raster geometry.
//------------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_video_timing_gen;

    typedef struct {
        int hv, hf, hs, hb;
        int vv, vf, vs, vb;
        int pd;
        bit pol;
    } cfg_t;

    typedef struct {
        logic [31:0] h, v, fc;
        logic        vb, de, hs, vs;
        logic [7:0]  col;
    } exp_t;

    // Instance A: small raster, default polarity and latency
    localparam int A_HV = 40, A_HF = 4, A_HS = 6, A_HB = 5;
    localparam int A_VV = 20, A_VF = 3, A_VS = 2, A_VB = 4;
    localparam int A_PD = 9;
    localparam bit A_POL = 1'b0;
    localparam int A_FRAME = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB);

    // Instance B: different raster, active-high syncs, no BG latency
    localparam int B_HV = 24, B_HF = 3, B_HS = 4, B_HB = 3;
    localparam int B_VV = 12, B_VF = 2, B_VS = 2, B_VB = 2;
    localparam int B_PD = 0;
    localparam bit B_POL = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [7:0]  color_in = 8'h00;

    logic [31:0] a_count_h, a_count_v, a_frame_count;
    logic [7:0]  a_color_out;
    logic        a_vga_hs, a_vga_vs, a_vga_de, a_vblank_pulse;

    logic [31:0] b_count_h, b_count_v, b_frame_count;
    logic [7:0]  b_color_out;
    logic        b_vga_hs, b_vga_vs, b_vga_de, b_vblank_pulse;

    longint      k = 0;          // edges since the last reset edge
    logic [7:0]  last_col = 8'h00; // color_in sampled at the last edge
    int          n_checks = 0;
    int          n_pass = 0;
    cfg_t        cfg_a, cfg_b;

    always #5 clk = ~clk;

    video_timing_gen #(
        .H_VISIBLE(A_HV), .H_FRONT(A_HF), .H_SYNC(A_HS), .H_BACK(A_HB),
        .V_VISIBLE(A_VV), .V_FRONT(A_VF), .V_SYNC(A_VS), .V_BACK(A_VB),
        .SYNC_POL(A_POL), .PIPELINE_DELAY(A_PD)
    ) u_dut_a (
        .clk(clk), .reset(reset),
        .count_h(a_count_h), .count_v(a_count_v),
        .color_in(color_in), .color_out(a_color_out),
        .vga_hs(a_vga_hs), .vga_vs(a_vga_vs), .vga_de(a_vga_de),
        .vblank_pulse(a_vblank_pulse), .frame_count(a_frame_count)
    );

    video_timing_gen #(
        .H_VISIBLE(B_HV), .H_FRONT(B_HF), .H_SYNC(B_HS), .H_BACK(B_HB),
        .V_VISIBLE(B_VV), .V_FRONT(B_VF), .V_SYNC(B_VS), .V_BACK(B_VB),
        .SYNC_POL(B_POL), .PIPELINE_DELAY(B_PD)
    ) u_dut_b (
        .clk(clk), .reset(reset),
        .count_h(b_count_h), .count_v(b_count_v),
        .color_in(color_in), .color_out(b_color_out),
        .vga_hs(b_vga_hs), .vga_vs(b_vga_vs), .vga_de(b_vga_de),
        .vblank_pulse(b_vblank_pulse), .frame_count(b_frame_count)
    );

    always @(posedge clk) begin
        if (!reset) k <= 0;
        else        k <= k + 1;
        last_col <= color_in;
    end

    // Expected outputs after kk post-release edges. The counters are the
    // raster position of kk; the video outputs show the position presented
    // pd+1 cycles earlier, inactive if that lies before release.
    function automatic exp_t model(cfg_t c, longint kk, logic [7:0] lc);
        exp_t   e;
        longint ht, vt, m, mh, mv;
        ht    = longint'(c.hv + c.hf + c.hs + c.hb);
        vt    = longint'(c.vv + c.vf + c.vs + c.vb);
        e.h   = 32'(kk % ht);
        e.v   = 32'((kk / ht) % vt);
        e.vb  = (kk % ht == 0) && ((kk / ht) % vt == longint'(c.vv));
        e.fc  = (kk >= longint'(c.vv) * ht) ? 32'((kk - longint'(c.vv) * ht) / (ht * vt) + 1) : 32'd0;
        m     = kk - longint'(c.pd + 1);
        if (m < 0) begin
            e.de  = 1'b0;
            e.hs  = ~c.pol;
            e.vs  = ~c.pol;
            e.col = 8'h00;
        end else begin
            mh    = m % ht;
            mv    = (m / ht) % vt;
            e.de  = (mh < c.hv) && (mv < c.vv);
            e.hs  = (mh >= c.hv + c.hf && mh < c.hv + c.hf + c.hs) ? c.pol : ~c.pol;
            e.vs  = (mv >= c.vv + c.vf && mv < c.vv + c.vf + c.vs) ? c.pol : ~c.pol;
            e.col = e.de ? lc : 8'h00;
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s k=%0d observed=%0h expected=%0h", tag, k, obs, expv);
    endtask

    task automatic check_all();
        exp_t ea, eb;
        ea = model(cfg_a, k, last_col);
        eb = model(cfg_b, k, last_col);
        chk("a.count_h",      a_count_h,               ea.h);
        chk("a.count_v",      a_count_v,               ea.v);
        chk("a.frame_count",  a_frame_count,           ea.fc);
        chk("a.vblank_pulse", 32'(a_vblank_pulse),     32'(ea.vb));
        chk("a.vga_de",       32'(a_vga_de),           32'(ea.de));
        chk("a.vga_hs",       32'(a_vga_hs),           32'(ea.hs));
        chk("a.vga_vs",       32'(a_vga_vs),           32'(ea.vs));
        chk("a.color_out",    32'(a_color_out),        32'(ea.col));
        chk("b.count_h",      b_count_h,               eb.h);
        chk("b.count_v",      b_count_v,               eb.v);
        chk("b.frame_count",  b_frame_count,           eb.fc);
        chk("b.vblank_pulse", 32'(b_vblank_pulse),     32'(eb.vb));
        chk("b.vga_de",       32'(b_vga_de),           32'(eb.de));
        chk("b.vga_hs",       32'(b_vga_hs),           32'(eb.hs));
        chk("b.vga_vs",       32'(b_vga_vs),           32'(eb.vs));
        chk("b.color_out",    32'(b_color_out),        32'(eb.col));
    endtask

    // Check the current cycle at the falling edge, then present a new color:
    // mostly random, often 0xFF so blanking outside the active area is hit.
    task automatic step();
        @(negedge clk);
        check_all();
        color_in = ($urandom_range(0, 3) == 0) ? 8'hFF : 8'($urandom);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        bit found;
        cfg_a = '{A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS, A_VB, A_PD, A_POL};
        cfg_b = '{B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS, B_VB, B_PD, B_POL};

        // Reset held: counters parked at zero, outputs inactive, no pulse
        reset = 1'b0;
        run(4);

        // Two full frames plus change from release
        reset = 1'b1;
        run(2 * A_FRAME + 100);

        // Directed reset mid-line / mid-frame on instance A
        found = 1'b0;
        for (int i = 0; i < 2 * A_FRAME && !found; i++) begin
            if (a_count_h == 32'd30 && a_count_v == 32'd10) found = 1'b1;
            else step();
        end
        n_checks++;
        if (found) n_pass++;
        else $error("FAIL mid_reset_wait observed=timeout expected=h30_v10");
        reset = 1'b0;
        step();
        reset = 1'b1;
        run(A_FRAME + 200);

        // Randomly placed resets of random length
        for (int r = 0; r < 4; r++) begin
            run($urandom_range(20, A_FRAME));
            reset = 1'b0;
            run($urandom_range(1, 3));
            reset = 1'b1;
            run($urandom_range(20, 200));
        end
        run(A_FRAME + 100);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/video_timing_gen.md
Name: video_timing_gen

Overview:
- Raster timing generator and output stage for the video path.
- Produces the pixel counters `count_h`/`count_v` that drive the character BG layer's `ext_count_h`/`ext_count_v`.
- Consumes the layer's 8-bit `ext_color` and emits it with sync and data-enable, both delayed to match the layer's fixed pipeline latency.
- Also provides a vblank pulse and a frame counter for the CPU side.

Parameters:
- `H_VISIBLE`, 640, active pixels per line
- `H_FRONT`, 16, horizontal front porch
- `H_SYNC`, 96, hsync width
- `H_BACK`, 48, horizontal back porch
- `V_VISIBLE`, 480, active lines
- `V_FRONT`, 10, vertical front porch
- `V_SYNC`, 2, vsync width
- `V_BACK`, 33, vertical back porch
- `SYNC_POL`, 0, active level of `vga_hs`/`vga_vs` (0 = active-low)
- `PIPELINE_DELAY`, 9, cycles from a count value to the matching `color_in` (BG layer latency)

Ports:
- `clk`  in  1  pixel clock (single clock domain)
- `reset`  in  1  synchronous, active-low reset (0 = reset)
- `count_h`  out  32  horizontal counter, 0..H_TOTAL-1, registered
- `count_v`  out  32  vertical counter, 0..V_TOTAL-1, registered
- `color_in`  in  8  pixel color from BG layer, valid PIPELINE_DELAY cycles after its count
- `color_out`  out  8  registered pixel color, 0 outside active area
- `vga_hs`  out  1  horizontal sync, latency-aligned
- `vga_vs`  out  1  vertical sync, latency-aligned
- `vga_de`  out  1  data enable, latency-aligned
- `vblank_pulse`  out  1  one-cycle pulse at start of vertical blanking (count domain)
- `frame_count`  out  32  frames completed, wraps at 2^32

Behaviour:
- Totals: H_TOTAL = sum of the four H params (800); V_TOTAL likewise (525).
- Counting:
  - `count_h` increments every cycle; at H_TOTAL-1 it wraps to 0.
  - On that wrap `count_v` increments; `count_v` wraps to 0 after V_TOTAL-1.
- Raw flags, combinational from the current counts:
  - de_raw = (h < H_VISIBLE) && (v < V_VISIBLE)
  - hs_raw active for H_VISIBLE+H_FRONT <= h < H_VISIBLE+H_FRONT+H_SYNC
  - vs_raw active for V_VISIBLE+V_FRONT <= v < V_VISIBLE+V_FRONT+V_SYNC
  - Sync active level = SYNC_POL.
- Alignment:
  - de/hs/vs raw flags pass through a PIPELINE_DELAY-stage shift register, then one output register.
  - `color_out` <= delayed_de ? `color_in` : 0.
  - Net: all four outputs in cycle n+PIPELINE_DELAY+1 correspond to the count presented in cycle n.
  - PIPELINE_DELAY = 0 is legal: the outputs are then registered once.
- `vblank_pulse`:
  - High for exactly one cycle, the cycle in which `count_h`==0 and `count_v`==V_VISIBLE.
  - `frame_count` increments on the same edge the pulse is generated; it wraps silently.
- Reset (`reset`==0 sampled at a rising edge):
  - `count_h`=0, `count_v`=0, `frame_count`=0, `vblank_pulse`=0, `color_out`=0, `vga_de`=0.
  - `vga_hs`/`vga_vs` = inactive level (~SYNC_POL).
  - All delay-line stages are cleared to de=0 and sync inactive.
- Reset mid-frame:
  - Same result as reset at power-up; no stale pixels or syncs may emerge from the delay line.
  - After release, outputs stay inactive for PIPELINE_DELAY+1 cycles, then follow the count from 0,0.
- Reset held: counts remain 0; no pulse is produced.

Test Plan:
- Release reset, run 800*525 cycles:
  - `count_h` sequence 0..799 repeating.
  - `count_v` steps once per line, wraps 524->0.
  - `frame_count`==1 after the first vblank.
- hsync placement (defaults): `vga_hs`=0 for exactly 96 cycles per line, starting 10 cycles after `count_h`==656 (i.e., when `count_h`==666); `vga_de`=1 for exactly 640 consecutive cycles per visible line.
- vsync placement: `vga_vs`=0 for exactly 2 lines (1600 cycles), beginning 10 cycles after `count_v`==490,`count_h`==0.
- Latency:
  - Drive `color_in`=`count_h`[7:0] delayed 9 cycles via a bench model.
  - `color_out` shows 0x00,0x01,... aligned with the rising `vga_de`.
  - `color_out`==0 whenever `vga_de`==0, even with `color_in`=0xFF.
- vblank: `vblank_pulse` high exactly once per frame, when `count_v`==480,`count_h`==0; its width is 1 cycle.
- Reset mid-line at `count_h`=300, `count_v`=100:
  - Next cycle `count_h`=0, `count_v`=0, `frame_count`=0.
  - `vga_de`=0 and syncs inactive for ≥10 cycles.
  - The first `vga_de`=1 occurs 10 cycles after release.
